spike_tx_layer: RTL and testbench
=================================

SPIKE_TX_LAYER -- requirements
Module: spike_tx_layer

Interface
REQ-001 Parameter CNT_BITS, default 3: width of each channel's pending-spike counter; max count = 2^CNT_BITS-1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 fire_in  input  8  one-cycle fire pulses from 8 source neurons; bit i = channel i.
REQ-005 en  input  1  launch enable; low blocks new requests only.
REQ-006 acks_in  input  8  per-channel acknowledge from the downstream output neuron; may be combinational from spikes_out.
REQ-007 clr_ovf  input  1  synchronous clear of ovf_out.
REQ-008 spikes_out  output  8  per-channel request lines, registered.
REQ-009 ovf_out  output  8  sticky per-channel overflow flags, registered.
REQ-010 busy  output  1  high when any channel is non-IDLE or has a nonzero pending count.

Function
REQ-011 Each channel i SHALL run an independent four-phase sender: spikes_out[i] rises, acks_in[i] rises, spikes_out[i] falls, acks_in[i] falls.
REQ-012 Per-channel states SHALL be IDLE (req 0), REQ (req 1), and REL (req 0); spikes_out[i] = 1 exactly in REQ.
REQ-013 IDLE->REQ SHALL occur when pend[i]!=0 and en=1; this is a launch, and pend[i] decrements on the same edge.
REQ-014 REQ->REL SHALL occur on the first edge sampling acks_in[i]=1; REQ SHALL hold indefinitely otherwise, with no timeout.
REQ-015 REL->IDLE SHALL occur on the first edge sampling acks_in[i]=0; REL SHALL never go directly to REQ.
REQ-016 pend[i] SHALL increment on an edge sampling fire_in[i]=1.
REQ-017 If fire_in[i]=1 and a launch occur on the same edge, pend[i] SHALL be unchanged.
REQ-018 Saturation: with pend[i]=max, fire_in[i]=1 and no launch, pend[i] SHALL stay at max and ovf_out[i] SHALL set; the spike is dropped.
REQ-019 ovf_out SHALL clear on an edge with clr_ovf=1; if a set and a clear coincide, set wins.
REQ-020 Latency: fire_in[i] sampled at edge k with pend=0, channel IDLE and en=1 SHALL give spikes_out[i]=1 after edge k+1.
REQ-021 With an immediate combinational ack, the minimum spike period per channel SHALL be 3 cycles (REQ, REL, IDLE).
REQ-022 acks_in[i] SHALL be ignored in IDLE; a stuck-high ack after a launch SHALL yield one REQ cycle, then REL held until the ack drops.
REQ-023 en=0 SHALL block IDLE->REQ only; in-flight REQ/REL channels SHALL complete, and fire_in SHALL still count.
REQ-024 Channels SHALL be fully concurrent; multiple spikes_out bits may be high simultaneously, with arbitration left to the receiver.
REQ-025 busy SHALL be combinational from registered state: OR over channels of (state!=IDLE or pend!=0).

Reset
REQ-026 resetn=0 SHALL asynchronously force all channels to IDLE, all pend to 0, spikes_out=8'h00, ovf_out=8'h00, and busy=0.
REQ-027 Reset mid-handshake SHALL drop in-flight and pending spikes; after release, channels SHALL start in IDLE regardless of acks_in.
REQ-028 The first launch after reset release SHALL require a new fire_in pulse.

Verification
REQ-029 Single spike: fire_in=8'h04 for 1 cycle, ack=spikes_out -> spikes_out=8'h04 for exactly 1 cycle, 2 cycles after the fire; busy then returns to 0.
REQ-030 Burst: fire_in[0]=1 for 5 consecutive cycles, CNT_BITS=3 -> 5 requests on bit 0, spaced 3 cycles apart; ovf_out=0.
REQ-031 Overflow: acks held 0, fire_in[1] pulsed 9 times -> pend[1]=7, ovf_out=8'h02; 1 REQ held; clr_ovf -> ovf_out=8'h00.
REQ-032 Concurrency with a priority receiver: fire_in=8'h81 -> spikes_out=8'h81; ack 8'h01 first; bit 7 is acked after bit 0 releases; exactly one spike per channel.
REQ-033 Simultaneous events: fire_in[3] on the launch edge with pend[3]=1 -> pend[3] remains 1, and a second request follows.
REQ-034 Reset mid-REQ: resetn=0 while spikes_out=8'h10 with pend=2 -> spikes_out drops to 0 immediately (asynchronously), and no request occurs after release without a new fire.

Source files
------------

// File: rtl/spike_tx_layer.sv
// Eight independent four-phase spike senders, each with a saturating pending-spike
// counter and a sticky overflow flag.
module spike_tx_layer #(
  parameter int unsigned CNT_BITS = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] fire_in,
  input  logic       en,
  input  logic [7:0] acks_in,
  input  logic       clr_ovf,
  output logic [7:0] spikes_out,
  output logic [7:0] ovf_out,
  output logic       busy
);

  localparam int unsigned NumCh = 8;
  localparam logic [CNT_BITS-1:0] PendMax = '1;
  localparam logic [CNT_BITS-1:0] PendOne = CNT_BITS'(1);

  // Bit 0 of the encoding is the request line, so spikes_out comes straight off a flop.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StRel  = 2'b10
  } state_e;

  state_e              state_q [NumCh];
  state_e              state_d [NumCh];
  logic [CNT_BITS-1:0] pend_q  [NumCh];
  logic [CNT_BITS-1:0] pend_d  [NumCh];
  logic [7:0]          ovf_q;
  logic [7:0]          ovf_d;
  logic [7:0]          launch;
  logic [7:0]          ovf_set;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NumCh; i++) begin
        state_q[i] <= StIdle;
        pend_q[i]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        state_q[i] <= state_d[i];
        pend_q[i]  <= pend_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  // Next-state logic: handshake sequencing and pending-count bookkeeping.
  always_comb begin
    launch  = '0;
    ovf_set = '0;
    for (int i = 0; i < NumCh; i++) begin
      state_d[i] = state_q[i];
      pend_d[i]  = pend_q[i];
      launch[i]  = (state_q[i] == StIdle) && (pend_q[i] != '0) && en;

      unique case (state_q[i])
        StIdle: if (launch[i]) state_d[i] = StReq;
        StReq:  if (acks_in[i]) state_d[i] = StRel;
        StRel:  if (!acks_in[i]) state_d[i] = StIdle;
        default: state_d[i] = StIdle;
      endcase

      // A fire coinciding with a launch leaves the count unchanged.
      if (fire_in[i] && !launch[i]) begin
        if (pend_q[i] == PendMax) begin
          ovf_set[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + PendOne;
        end
      end else if (!fire_in[i] && launch[i]) begin
        pend_d[i] = pend_q[i] - PendOne;
      end
    end
    // Set beats clear when both land on the same edge.
    ovf_d = (ovf_q & ~{8{clr_ovf}}) | ovf_set;
  end

  // Outputs decoded from registered state only.
  always_comb begin
    spikes_out = '0;
    busy       = 1'b0;
    for (int i = 0; i < NumCh; i++) begin
      spikes_out[i] = (state_q[i] == StReq);
      busy          = busy | (state_q[i] != StIdle) | (pend_q[i] != '0);
    end
    ovf_out = ovf_q;
  end

endmodule

// File: tb/tb_spike_tx_layer.sv
// Directed bench for spike_tx_layer: inputs change and outputs are sampled on the
// falling clock edge, acks come from a selectable receiver model.
module tb_spike_tx_layer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] fire_in;
  logic       en;
  logic [7:0] acks_in;
  logic       clr_ovf;
  logic [7:0] spikes_out;
  logic [7:0] ovf_out;
  logic       busy;

  // 0: manual acks, 1: echo receiver, 2: priority receiver (bit 0 over bit 7)
  int         ack_mode;
  logic [7:0] acks_man;
  int         n_checks = 0;
  int         n_fail   = 0;

  spike_tx_layer #(.CNT_BITS(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .fire_in   (fire_in),
    .en        (en),
    .acks_in   (acks_in),
    .clr_ovf   (clr_ovf),
    .spikes_out(spikes_out),
    .ovf_out   (ovf_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    acks_in = 8'h00;
    case (ack_mode)
      0: acks_in = acks_man;
      1: acks_in = spikes_out;
      2: acks_in = spikes_out[0] ? 8'h01 : (spikes_out[7] ? 8'h80 : 8'h00);
      default: acks_in = 8'h00;
    endcase
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0; fire_in = 8'h00; en = 1'b1; clr_ovf = 1'b0;
    ack_mode = 0; acks_man = 8'h00;
    step(2);
    n_checks++; if (spikes_out !== 8'h00) begin n_fail++;
      $display("FAIL reset_spikes got %h want 00", spikes_out); end
    n_checks++; if (ovf_out !== 8'h00) begin n_fail++;
      $display("FAIL reset_ovf got %h want 00", ovf_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", busy); end
    resetn = 1'b1;
    step(2);
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_release got spikes=%h busy=%b want 00/0", spikes_out, busy); end
  endtask

  task automatic test_single;
    ack_mode = 1; fire_in = 8'h04;
    step(1); fire_in = 8'h00;
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b1) begin n_fail++;
      $display("FAIL single_t0 got spikes=%h busy=%b want 00/1", spikes_out, busy); end
    step(1);
    n_checks++; if (spikes_out !== 8'h04) begin n_fail++;
      $display("FAIL single_req got %h want 04", spikes_out); end
    step(1);
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b1) begin n_fail++;
      $display("FAIL single_rel got spikes=%h busy=%b want 00/1", spikes_out, busy); end
    step(1);
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b0) begin n_fail++;
      $display("FAIL single_idle got spikes=%h busy=%b want 00/0", spikes_out, busy); end
  endtask

  task automatic test_burst;
    logic exp;
    ack_mode = 1; fire_in = 8'h01;
    for (int t = 0; t < 20; t++) begin
      step(1);
      fire_in = (t < 4) ? 8'h01 : 8'h00;
      exp = (t % 3 == 1) && (t <= 13);
      n_checks++; if (spikes_out !== {7'h00, exp}) begin n_fail++;
        $display("FAIL burst_t%0d got %h want %h", t, spikes_out, {7'h00, exp}); end
    end
    n_checks++; if (ovf_out !== 8'h00 || busy !== 1'b0) begin n_fail++;
      $display("FAIL burst_end got ovf=%h busy=%b want 00/0", ovf_out, busy); end
  endtask

  task automatic test_overflow;
    ack_mode = 0; acks_man = 8'h00; fire_in = 8'h02;
    step(9); fire_in = 8'h00;
    n_checks++; if (ovf_out !== 8'h02) begin n_fail++;
      $display("FAIL ovf_set got %h want 02", ovf_out); end
    n_checks++; if (dut.pend_q[1] !== 3'd7) begin n_fail++;
      $display("FAIL ovf_pend got %0d want 7", dut.pend_q[1]); end
    step(3);
    n_checks++; if (spikes_out !== 8'h02) begin n_fail++;
      $display("FAIL ovf_req_held got %h want 02", spikes_out); end
    fire_in = 8'h02; clr_ovf = 1'b1;
    step(1); fire_in = 8'h00;
    n_checks++; if (ovf_out !== 8'h02) begin n_fail++;
      $display("FAIL ovf_set_wins got %h want 02", ovf_out); end
    step(1); clr_ovf = 1'b0;
    n_checks++; if (ovf_out !== 8'h00) begin n_fail++;
      $display("FAIL ovf_clear got %h want 00", ovf_out); end
    ack_mode = 1;
    step(30);
    n_checks++; if (busy !== 1'b0 || ovf_out !== 8'h00) begin n_fail++;
      $display("FAIL ovf_drain got busy=%b ovf=%h want 0/00", busy, ovf_out); end
  endtask

  task automatic test_concurrency;
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h81, 8'h80, 8'h00, 8'h00};
    ack_mode = 2; fire_in = 8'h81;
    step(1); fire_in = 8'h00;
    for (int t = 0; t < 4; t++) begin
      step(1);
      n_checks++; if (spikes_out !== exp_seq[t]) begin n_fail++;
        $display("FAIL conc_t%0d got %h want %h", t, spikes_out, exp_seq[t]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL conc_busy got %b want 0", busy); end
  endtask

  task automatic test_simultaneous;
    ack_mode = 1; fire_in = 8'h08;
    step(1);
    step(1); fire_in = 8'h00;
    n_checks++; if (spikes_out !== 8'h08 || dut.pend_q[3] !== 3'd1) begin n_fail++;
      $display("FAIL simul_launch got spikes=%h pend=%0d want 08/1", spikes_out, dut.pend_q[3]); end
    step(2);
    n_checks++; if (spikes_out !== 8'h00) begin n_fail++;
      $display("FAIL simul_gap got %h want 00", spikes_out); end
    step(1);
    n_checks++; if (spikes_out !== 8'h08) begin n_fail++;
      $display("FAIL simul_second got %h want 08", spikes_out); end
    step(3);
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL simul_busy got %b want 0", busy); end
  endtask

  task automatic test_enable;
    ack_mode = 1; en = 1'b0; fire_in = 8'h04;
    step(1); fire_in = 8'h00;
    step(3);
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b1 || dut.pend_q[2] !== 3'd1) begin
      n_fail++;
      $display("FAIL en_block got spikes=%h busy=%b pend=%0d want 00/1/1",
               spikes_out, busy, dut.pend_q[2]); end
    en = 1'b1;
    step(1);
    n_checks++; if (spikes_out !== 8'h04) begin n_fail++;
      $display("FAIL en_launch got %h want 04", spikes_out); end
    en = 1'b0;
    step(2);
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b0) begin n_fail++;
      $display("FAIL en_inflight got spikes=%h busy=%b want 00/0", spikes_out, busy); end
    en = 1'b1;
  endtask

  task automatic test_stuck_ack;
    ack_mode = 0; acks_man = 8'h20; fire_in = 8'h20;
    step(1); fire_in = 8'h00;
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b1) begin n_fail++;
      $display("FAIL stuck_idle got spikes=%h busy=%b want 00/1", spikes_out, busy); end
    step(1);
    n_checks++; if (spikes_out !== 8'h20) begin n_fail++;
      $display("FAIL stuck_req got %h want 20", spikes_out); end
    step(4);
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b1) begin n_fail++;
      $display("FAIL stuck_rel got spikes=%h busy=%b want 00/1", spikes_out, busy); end
    acks_man = 8'h00;
    step(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL stuck_release got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    ack_mode = 0; acks_man = 8'h00; fire_in = 8'h10;
    step(3); fire_in = 8'h00;
    n_checks++; if (spikes_out !== 8'h10 || dut.pend_q[4] !== 3'd2) begin n_fail++;
      $display("FAIL rmid_setup got spikes=%h pend=%0d want 10/2", spikes_out, dut.pend_q[4]); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rmid_async got spikes=%h busy=%b want 00/0", spikes_out, busy); end
    step(1);
    acks_man = 8'hff; resetn = 1'b1;
    step(5);
    n_checks++; if (spikes_out !== 8'h00 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rmid_after got spikes=%h busy=%b want 00/0", spikes_out, busy); end
    acks_man = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_concurrency();
    test_simultaneous();
    test_enable();
    test_stuck_ack();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
